// File: rtl/mprj_qspi_pad_ctrl_if.sv
// Wishbone slave bus bundle for the quad-SPI pad controller.
// The SoC side drives the master modport; the pad controller takes the slave modport.
interface mprj_qspi_pad_ctrl_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/mprj_qspi_pad_ctrl.sv
// Bidirectional pad controller for NCH quad-SPI channels.
// Registers pad outputs and active-low output enables, synchronises pad inputs,
// and offers per-channel enable, loopback, forced-input masks and sticky edge
// flags with a level interrupt, all behind a Wishbone slave.
module mprj_qspi_pad_ctrl #(
   parameter int          NCH         = 2,
   parameter int          DQW         = 4,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] BASE_ADR    = 32'h3000_0000
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_ni,
   mprj_qspi_pad_ctrl_if.slave  wbs,
   input  logic [NCH*DQW-1:0]   core_dq_o,
   input  logic [NCH*DQW-1:0]   core_dq_oe,
   output logic [NCH*DQW-1:0]   core_dq_i,
   input  logic [NCH*DQW-1:0]   pad_dq_i,
   output logic [NCH*DQW-1:0]   pad_dq_o,
   output logic [NCH*DQW-1:0]   pad_dq_oeb,
   output logic                 irq_o
);

   localparam int         W        = NCH * DQW;
   localparam logic [5:0] EDGE_WA  = 6'h10;
   localparam logic [5:0] PADIN_WA = 6'h11;

   // control registers
   logic           r_en  [NCH];
   logic           r_lb  [NCH];
   logic           r_ien [NCH];
   logic [DQW-1:0] r_frc [NCH];
   logic [W-1:0]   r_edge;

   // bus response
   logic           r_ack;
   logic [31:0]    r_dat;

   // datapath
   logic [W-1:0]   r_sync [SYNC_STAGES];
   logic [W-1:0]   r_prev;
   logic [W-1:0]   r_pad_o;
   logic [W-1:0]   r_oeb;
   logic [W-1:0]   r_lbq;
   logic           r_irq;

   logic           w_acc, w_hit, w_wr, w_irq;
   logic [5:0]     w_wa;
   logic [31:0]    w_bmask, w_wmask, w_rd;
   logic [W-1:0]   w_sync, w_set, w_clr;
   logic [W-1:0]   w_en_line, w_lb_line, w_frc_line;
   logic           w_unused;

   // A new access is taken only while no ack is outstanding, which spaces acks 2 cycles apart.
   assign w_acc   = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~r_ack;
   assign w_hit   = (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);
   assign w_wa    = wbs.wbs_adr_i[7:2];
   assign w_wr    = w_acc & wbs.wbs_we_i & w_hit;
   assign w_bmask = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                     {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};
   assign w_wmask = wbs.wbs_dat_i & w_bmask;
   assign w_sync  = r_sync[SYNC_STAGES-1];
   assign w_unused = &{1'b0, wbs.wbs_adr_i[1:0], wbs.wbs_dat_i};

   // Spread per-channel controls onto the individual dq lines.
   always_comb begin
      w_en_line  = '0;
      w_lb_line  = '0;
      w_frc_line = '0;
      for (int i = 0; i < W; i++) begin
         w_en_line[i]  = r_en[i / DQW];
         w_lb_line[i]  = r_lb[i / DQW];
         w_frc_line[i] = r_frc[i / DQW][i % DQW];
      end
   end

   // Read data mux; anything outside the map reads as zero.
   always_comb begin
      w_rd = '0;
      if (w_hit) begin
         for (int c = 0; c < NCH; c++) begin
            if (w_wa == 6'(c)) begin
               w_rd[0]       = r_en[c];
               w_rd[1]       = r_lb[c];
               w_rd[2]       = r_ien[c];
               w_rd[8 +: DQW] = r_frc[c];
            end
         end
         if (w_wa == EDGE_WA) begin
            w_rd[W-1:0] = r_edge;
         end else if (w_wa == PADIN_WA) begin
            w_rd[W-1:0] = w_sync;
         end
      end
   end

   // Edge flags: a change on a listening line sets, a W1C clears, and set beats clear.
   assign w_set = (w_sync ^ r_prev) & w_en_line & r_oeb;
   assign w_clr = (w_wr && (w_wa == EDGE_WA)) ? w_wmask[W-1:0] : '0;

   // Interrupt request from any channel whose edge flags are armed.
   always_comb begin
      w_irq = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         if (r_ien[c] && (|r_edge[c*DQW +: DQW])) w_irq = 1'b1;
      end
   end

   // Wishbone ack pulse and read data, zero whenever ack is low.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_acc;
         r_dat <= (w_acc && !wbs.wbs_we_i) ? w_rd : '0;
      end
   end

   // Per-channel CTRL registers with byte-lane write gating.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         for (int c = 0; c < NCH; c++) begin
            r_en[c]  <= 1'b0;
            r_lb[c]  <= 1'b0;
            r_ien[c] <= 1'b0;
            r_frc[c] <= '0;
         end
      end else if (w_wr) begin
         for (int c = 0; c < NCH; c++) begin
            if (w_wa == 6'(c)) begin
               if (wbs.wbs_sel_i[0]) begin
                  r_en[c]  <= wbs.wbs_dat_i[0];
                  r_lb[c]  <= wbs.wbs_dat_i[1];
                  r_ien[c] <= wbs.wbs_dat_i[2];
               end
               if (wbs.wbs_sel_i[1]) r_frc[c] <= wbs.wbs_dat_i[8 +: DQW];
            end
         end
      end
   end

   // Input synchroniser chain plus the previous-value copy used for edge detection.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
         r_prev <= '0;
      end else begin
         r_sync[0] <= pad_dq_i;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
         r_prev <= w_sync;
      end
   end

   // Pad output data and enable registered together so turnaround stays aligned.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_pad_o <= '0;
         r_oeb   <= '1;
         r_lbq   <= '0;
      end else begin
         r_pad_o <= core_dq_o & w_en_line;
         r_oeb   <= ~(w_en_line & core_dq_oe & ~w_frc_line);
         r_lbq   <= r_pad_o;
      end
   end

   // Sticky edge flags and the registered interrupt level.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_edge <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_edge <= (r_edge & ~w_clr) | w_set;
         r_irq  <= w_irq;
      end
   end

   assign core_dq_i     = w_en_line & ((w_lb_line & r_lbq) | (~w_lb_line & w_sync));
   assign pad_dq_o      = r_pad_o;
   assign pad_dq_oeb    = r_oeb;
   assign irq_o         = r_irq;
   assign wbs.wbs_ack_o = r_ack;
   assign wbs.wbs_dat_o = r_dat;

endmodule

// File: tb/tb_mprj_qspi_pad_ctrl.sv
// Randomised bench for the quad-SPI pad controller with a behavioural reference model.
module tb_mprj_qspi_pad_ctrl;
   localparam int          NCH  = 2;
   localparam int          DQW  = 4;
   localparam int          S    = 2;
   localparam int          W    = NCH * DQW;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] core_dq_o, core_dq_oe, core_dq_i, pad_dq_i, pad_dq_o, pad_dq_oeb;
   logic         irq_o;

   mprj_qspi_pad_ctrl_if wbs ();

   mprj_qspi_pad_ctrl #(.NCH(NCH), .DQW(DQW), .SYNC_STAGES(S), .BASE_ADR(BASE)) u_dut (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n),
      .wbs        (wbs),
      .core_dq_o  (core_dq_o),
      .core_dq_oe (core_dq_oe),
      .core_dq_i  (core_dq_i),
      .pad_dq_i   (pad_dq_i),
      .pad_dq_o   (pad_dq_o),
      .pad_dq_oeb (pad_dq_oeb),
      .irq_o      (irq_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: visible state at the current sampling point.
   bit           m_en [NCH];
   bit           m_lb [NCH];
   bit           m_ien[NCH];
   bit [DQW-1:0] m_frc[NCH];
   bit [W-1:0]   m_edge, m_pad_o, m_oeb, m_prev_pad_o, m_sync, m_prev_sync;
   bit           m_ack, m_irq;
   bit [31:0]    m_dat;
   bit [W-1:0]   m_hist[$];

   bit [W-1:0]   cur_co, cur_oe, cur_pin;
   logic [31:0]  obs_dat;
   logic         obs_ack;

   task automatic m_reset();
      for (int c = 0; c < NCH; c++) begin
         m_en[c] = 0; m_lb[c] = 0; m_ien[c] = 0; m_frc[c] = '0;
      end
      m_edge = '0; m_pad_o = '0; m_oeb = '1; m_prev_pad_o = '0;
      m_sync = '0; m_prev_sync = '0; m_ack = 0; m_irq = 0; m_dat = '0;
      m_hist.delete();
      for (int k = 0; k < S; k++) m_hist.push_back('0);
   endtask

   function automatic bit [31:0] m_read(input bit [31:0] a);
      bit [31:0] r;
      bit [5:0]  wa;
      r = '0;
      wa = a[7:2];
      if (a[31:8] != BASE[31:8]) return r;
      for (int c = 0; c < NCH; c++) begin
         if (wa == 6'(c)) begin
            r[0] = m_en[c]; r[1] = m_lb[c]; r[2] = m_ien[c]; r[8 +: DQW] = m_frc[c];
         end
      end
      if (wa == 6'h10) r[W-1:0] = m_edge;
      if (wa == 6'h11) r[W-1:0] = m_sync;
      return r;
   endfunction

   // One clock: drive inputs now, predict, advance to the next falling edge, compare.
   task automatic step(input bit stb, input bit we, input bit [31:0] adr, input bit [31:0] dat,
                       input bit [3:0] sel, input bit [W-1:0] co, input bit [W-1:0] oe,
                       input bit [W-1:0] pin);
      bit           acc, hit, n_ack, n_irq;
      bit [31:0]    n_dat, bm;
      bit [W-1:0]   n_pad_o, n_oeb, n_edge, set_v, clr_v, exp_ci;
      int           c;
      wbs.wbs_stb_i = stb; wbs.wbs_cyc_i = stb; wbs.wbs_we_i = we;
      wbs.wbs_adr_i = adr; wbs.wbs_dat_i = dat; wbs.wbs_sel_i = sel;
      core_dq_o = co; core_dq_oe = oe; pad_dq_i = pin;
      acc   = stb && !m_ack;
      hit   = (adr[31:8] == BASE[31:8]);
      n_ack = acc;
      n_dat = (acc && !we) ? m_read(adr) : 32'h0;
      for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{sel[b]}};
      n_irq = 0;
      for (int k = 0; k < NCH; k++) if (m_ien[k] && (m_edge[k*DQW +: DQW] != 0)) n_irq = 1;
      for (int i = 0; i < W; i++) begin
         c = i / DQW;
         n_pad_o[i] = m_en[c] && co[i];
         n_oeb[i]   = !(m_en[c] && oe[i] && !m_frc[c][i % DQW]);
         set_v[i]   = (m_sync[i] != m_prev_sync[i]) && m_en[c] && m_oeb[i];
      end
      clr_v = (acc && we && hit && adr[7:2] == 6'h10) ? W'(dat & bm) : '0;
      n_edge = (m_edge & ~clr_v) | set_v;
      @(posedge clk);
      @(negedge clk);
      if (acc && we && hit) begin
         for (int k = 0; k < NCH; k++) begin
            if (adr[7:2] == 6'(k)) begin
               if (sel[0]) begin m_en[k] = dat[0]; m_lb[k] = dat[1]; m_ien[k] = dat[2]; end
               if (sel[1]) m_frc[k] = dat[8 +: DQW];
            end
         end
      end
      m_prev_pad_o = m_pad_o;
      m_prev_sync  = m_sync;
      m_hist.push_back(pin);
      void'(m_hist.pop_front());
      m_sync  = m_hist[0];
      m_pad_o = n_pad_o; m_oeb = n_oeb; m_edge = n_edge;
      m_ack = n_ack; m_dat = n_dat; m_irq = n_irq;
      for (int i = 0; i < W; i++) begin
         c = i / DQW;
         exp_ci[i] = m_en[c] ? (m_lb[c] ? m_prev_pad_o[i] : m_sync[i]) : 1'b0;
      end
      chk("pad_dq_o",   32'(pad_dq_o),   32'(m_pad_o));
      chk("pad_dq_oeb", 32'(pad_dq_oeb), 32'(m_oeb));
      chk("core_dq_i",  32'(core_dq_i),  32'(exp_ci));
      chk("ack",        32'(wbs.wbs_ack_o), 32'(m_ack));
      chk("dat_o",      wbs.wbs_dat_o,   m_dat);
      chk("irq",        32'(irq_o),      32'(m_irq));
      obs_dat = wbs.wbs_dat_o;
      obs_ack = wbs.wbs_ack_o;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, '0, '0, '0, cur_co, cur_oe, cur_pin);
   endtask

   task automatic wb_acc(input bit we, input bit [31:0] adr, input bit [31:0] dat, input bit [3:0] sel);
      step(1, we, adr, dat, sel, cur_co, cur_oe, cur_pin);
      step(0, 0, '0, '0, '0, cur_co, cur_oe, cur_pin);
   endtask

   bit [31:0] adr_tab [7];
   bit [31:0] ack_dat;
   int        ack_cnt;

   initial begin
      adr_tab[0] = BASE;         adr_tab[1] = BASE + 32'h4;  adr_tab[2] = BASE + 32'h40;
      adr_tab[3] = BASE + 32'h44; adr_tab[4] = BASE + 32'h80; adr_tab[5] = BASE + 32'h3C;
      adr_tab[6] = 32'h2000_0004;
      wbs.wbs_stb_i = 0; wbs.wbs_cyc_i = 0; wbs.wbs_we_i = 0;
      wbs.wbs_adr_i = '0; wbs.wbs_dat_i = '0; wbs.wbs_sel_i = '0;
      core_dq_o = '0; core_dq_oe = '0; pad_dq_i = '0;
      cur_co = '0; cur_oe = '0; cur_pin = '0;
      m_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_oeb",   32'(pad_dq_oeb), 32'hFF);
      chk("rst_pad_o", 32'(pad_dq_o),   32'h0);
      chk("rst_ack",   32'(wbs.wbs_ack_o), 32'h0);
      chk("rst_irq",   32'(irq_o),      32'h0);
      rst_n = 1'b1;

      // Output path and turnaround on channel 0
      wb_acc(1, BASE, 32'h1, 4'hF);
      cur_co = 8'h0A; cur_oe = 8'h0F;
      idle(1);
      chk("ch0_data", 32'(pad_dq_o[3:0]),   32'hA);
      chk("ch0_oeb",  32'(pad_dq_oeb[3:0]), 32'h0);
      cur_oe = 8'h00;
      idle(1);
      chk("ch0_oe_drop", 32'(pad_dq_oeb[3:0]), 32'hF);

      // Forced-input mask and input synchroniser latency
      cur_oe = 8'h0F;
      wb_acc(1, BASE, 32'h301, 4'hF);
      idle(1);
      chk("force_oeb", 32'(pad_dq_oeb[3:0]), 32'h3);
      cur_pin = 8'h03;
      idle(2);
      chk("sync_lat", 32'(core_dq_i[1:0]), 32'h3);

      // Byte-lane gating leaves FORCE_IN intact
      wb_acc(1, BASE, 32'h0000_0F01, 4'b0001);
      step(1, 0, BASE, '0, 4'hF, cur_co, cur_oe, cur_pin);
      chk("sel_gate", obs_dat, 32'h301);
      idle(1);

      // Loopback
      cur_co = 8'h05;
      wb_acc(1, BASE, 32'h3, 4'hF);
      idle(2);
      chk("loopback", 32'(core_dq_i[3:0]), 32'h5);

      // Edge capture, interrupt, and set-beats-clear on channel 1
      wb_acc(1, BASE, 32'h0, 4'hF);
      wb_acc(1, BASE + 32'h4, 32'h5, 4'hF);
      cur_oe = 8'h00; cur_pin = 8'h00;
      idle(4);
      wb_acc(1, BASE + 32'h40, 32'hFF, 4'hF);
      idle(2);
      cur_pin = 8'h10;
      idle(2);
      step(1, 1, BASE + 32'h40, 32'h10, 4'hF, cur_co, cur_oe, cur_pin);
      idle(1);
      step(1, 0, BASE + 32'h40, '0, 4'hF, cur_co, cur_oe, cur_pin);
      chk("w1c_set_wins", obs_dat, 32'h10);
      chk("irq_set", 32'(irq_o), 32'h1);
      idle(1);
      wb_acc(1, BASE + 32'h40, 32'h10, 4'hF);
      idle(1);
      chk("irq_clr", 32'(irq_o), 32'h0);

      // Unmapped read and held strobe
      step(1, 0, BASE + 32'h80, '0, 4'hF, cur_co, cur_oe, cur_pin);
      chk("unmapped_ack", 32'(obs_ack), 32'h1);
      chk("unmapped_dat", obs_dat, 32'h0);
      idle(1);
      ack_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         step(1, 0, BASE + 32'h80, '0, 4'hF, cur_co, cur_oe, cur_pin);
         if (obs_ack) ack_cnt++;
      end
      chk("held_stb_acks", 32'(ack_cnt), 32'd4);
      idle(1);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         bit st;
         st = ($urandom_range(0, 9) < 4);
         if ($urandom_range(0, 7) == 0) cur_oe = 8'($urandom);
         cur_co  = 8'($urandom);
         cur_pin = cur_pin ^ 8'($urandom & $urandom & $urandom);
         step(st, 1'($urandom), adr_tab[$urandom_range(0, 6)],
              ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 7)),
              4'($urandom), cur_co, cur_oe, cur_pin);
      end

      // Reset asserted mid-cycle while an ack is showing
      idle(1);
      step(1, 0, BASE + 32'h44, '0, 4'hF, cur_co, cur_oe, cur_pin);
      wbs.wbs_stb_i = 0; wbs.wbs_cyc_i = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_oeb",   32'(pad_dq_oeb), 32'hFF);
      chk("mid_rst_pad_o", 32'(pad_dq_o),   32'h0);
      chk("mid_rst_ack",   32'(wbs.wbs_ack_o), 32'h0);
      chk("mid_rst_dat",   wbs.wbs_dat_o,   32'h0);
      chk("mid_rst_irq",   32'(irq_o),      32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();
      cur_pin = 8'($urandom);
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 7) == 0) cur_oe = 8'($urandom);
         cur_co  = 8'($urandom);
         cur_pin = cur_pin ^ 8'($urandom & $urandom & $urandom);
         step($urandom_range(0, 9) < 4, 1'($urandom), adr_tab[$urandom_range(0, 6)],
              $urandom, 4'($urandom), cur_co, cur_oe, cur_pin);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
